// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: one handshaked word-bus transaction per access,
// with lane steering for stores, load extension, fault and timeout flags.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_mem_re,
  input  logic        M_mem_we,
  input  logic [2:0]  M_funct3,
  input  logic [31:0] M_alu_o,
  input  logic [31:0] M_rf_wd,
  output logic [31:0] M_dm_rd,
  output logic        M_stall,
  output logic        M_fault,
  output logic        M_bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   dm_rd_q, dm_rd_d;
  logic          fault_q, fault_d;
  logic          bus_err_q, bus_err_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    lane_q, lane_d;

  logic          access;
  logic          illegal;
  logic          fault;
  logic          ack;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;

  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  lane,
                                           input logic [31:0] w);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {lane, 3'b000};
    b = shifted[7:0];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'h0, b};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Decode the M-stage request: legality, byte enables and replicated store data.
  always_comb begin
    access = M_mem_re | M_mem_we;
    case (M_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = M_mem_we;
      default:                illegal = 1'b1;
    endcase
    fault = (M_mem_re & M_mem_we) | illegal
          | ((M_funct3[1:0] == 2'b01) & M_alu_o[0])
          | ((M_funct3[1:0] == 2'b10) & (M_alu_o[1:0] != 2'b00));

    case (M_funct3[1:0])
      2'b00:   be_new = 4'b0001 << M_alu_o[1:0];
      2'b01:   be_new = 4'b0011 << {M_alu_o[1], 1'b0};
      default: be_new = 4'b1111;
    endcase

    if (!M_mem_we) begin
      wdata_new = 32'h0;
    end else begin
      case (M_funct3[1:0])
        2'b00:   wdata_new = {4{M_rf_wd[7:0]}};
        2'b01:   wdata_new = {2{M_rf_wd[15:0]}};
        default: wdata_new = M_rf_wd;
      endcase
    end
  end

  // An ack only counts while a request is actually on the bus.
  assign ack = bus_ack & bus_req_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    dm_rd_d     = dm_rd_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    fault_d     = 1'b0;
    bus_err_d   = 1'b0;
    M_stall     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (access) begin
          if (fault) begin
            fault_d = 1'b1;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = M_mem_we;
            bus_addr_d  = {M_alu_o[31:2], 2'b00};
            bus_wdata_d = wdata_new;
            bus_be_d    = be_new;
            funct3_d    = M_funct3;
            lane_d      = M_alu_o[1:0];
            M_stall     = 1'b1;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        M_stall = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            dm_rd_d = fmt_load(funct3_q, lane_q, bus_rdata);
          end
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!bus_we_q) begin
            dm_rd_d = 32'h0;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d     = '0;
        bus_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
      dm_rd_q     <= 32'h0;
      fault_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      dm_rd_q     <= dm_rd_d;
      fault_q     <= fault_d;
      bus_err_q   <= bus_err_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
    end
  end

  assign M_dm_rd   = dm_rd_q;
  assign M_fault   = fault_q;
  assign M_bus_err = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu: table of accesses with hand-computed
// bus fields and load results, plus timeout, late-ack and mid-transaction reset sequences.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic        M_mem_re;
  logic        M_mem_we;
  logic [2:0]  M_funct3;
  logic [31:0] M_alu_o;
  logic [31:0] M_rf_wd;
  logic [31:0] M_dm_rd;
  logic        M_stall;
  logic        M_fault;
  logic        M_bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int tests_run;
  int tests_failed;

  mem_stage_lsu #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .M_mem_re  (M_mem_re),
    .M_mem_we  (M_mem_we),
    .M_funct3  (M_funct3),
    .M_alu_o   (M_alu_o),
    .M_rf_wd   (M_rf_wd),
    .M_dm_rd   (M_dm_rd),
    .M_stall   (M_stall),
    .M_fault   (M_fault),
    .M_bus_err (M_bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_cycle;
    logic        exp_fault;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_dm;
    int          exp_stall;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string name, input logic re, input logic we,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata,
                              input int ack_cycle, input logic exp_fault,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_dm,
                              input int exp_stall, input logic exp_err);
    vec_t v;
    v.name = name; v.re = re; v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.rdata = rdata; v.ack_cycle = ack_cycle; v.exp_fault = exp_fault;
    v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    v.exp_dm = exp_dm; v.exp_stall = exp_stall; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idle_inputs();
    M_mem_re = 1'b0;
    M_mem_we = 1'b0;
    M_funct3 = 3'b000;
    M_alu_o  = 32'h0;
    M_rf_wd  = 32'h0;
  endtask

  // Drives one M-stage access and follows it through to the pipeline release.
  task automatic applyStimulus(input vec_t v);
    int  stall_cnt;
    int  busy;
    bit  done;
    @(negedge clk);
    M_mem_re  = v.re;
    M_mem_we  = v.we;
    M_funct3  = v.f3;
    M_alu_o   = v.addr;
    M_rf_wd   = v.wd;
    bus_ack   = 1'b0;
    #1;
    checkOutput({v.name, ".stall_c0"}, {31'h0, M_stall}, {31'h0, ~v.exp_fault});
    if (v.exp_fault) begin
      @(negedge clk);
      checkOutput({v.name, ".fault"},   {31'h0, M_fault}, 32'h1);
      checkOutput({v.name, ".no_req"},  {31'h0, bus_req}, 32'h0);
      checkOutput({v.name, ".stall"},   {31'h0, M_stall}, 32'h0);
      checkOutput({v.name, ".dm_rd"},   M_dm_rd, v.exp_dm);
      idle_inputs();
      @(negedge clk);
      checkOutput({v.name, ".fault_1cyc"}, {31'h0, M_fault}, 32'h0);
      checkOutput({v.name, ".no_req2"},    {31'h0, bus_req}, 32'h0);
    end else begin
      stall_cnt = 1;
      busy      = 0;
      done      = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (M_stall) begin
          stall_cnt++;
          busy++;
          if (busy == 1) begin
            checkOutput({v.name, ".req"},   {31'h0, bus_req}, 32'h1);
            checkOutput({v.name, ".we"},    {31'h0, bus_we}, {31'h0, v.we});
            checkOutput({v.name, ".addr"},  bus_addr, v.exp_addr);
            checkOutput({v.name, ".be"},    {28'h0, bus_be}, {28'h0, v.exp_be});
            checkOutput({v.name, ".wdata"}, bus_wdata, v.exp_wdata);
          end
          bus_ack   = (busy == v.ack_cycle);
          bus_rdata = (busy == v.ack_cycle) ? v.rdata : 32'h5A5A_5A5A;
        end else begin
          done = 1'b1;
        end
      end
      bus_ack = 1'b0;
      checkOutput({v.name, ".done_in_bound"}, {31'h0, done}, 32'h1);
      checkOutput({v.name, ".stall_cycles"}, stall_cnt, v.exp_stall);
      checkOutput({v.name, ".dm_rd"},   M_dm_rd, v.exp_dm);
      checkOutput({v.name, ".req_drop"}, {31'h0, bus_req}, 32'h0);
      checkOutput({v.name, ".bus_err"}, {31'h0, M_bus_err}, {31'h0, v.exp_err});
      checkOutput({v.name, ".no_fault"}, {31'h0, M_fault}, 32'h0);
      idle_inputs();
      @(negedge clk);
      checkOutput({v.name, ".err_1cyc"}, {31'h0, M_bus_err}, 32'h0);
    end
  endtask

  initial begin
    vec_t v;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus_ack      = 1'b0;
    bus_rdata    = 32'h0;
    idle_inputs();

    //       name      re we  f3      addr          wd            rdata         ack flt exp_addr      be       wdata         dm            stall err
    vecs[0]  = mk("lw",    1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 4,  0);
    vecs[1]  = mk("lb",    1, 0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_FF7F, 1, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'hFFFF_FF80, 2,  0);
    vecs[2]  = mk("lbu",   1, 0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_FF7F, 2, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'h0000_0080, 3,  0);
    vecs[3]  = mk("lhu",   1, 0, 3'b101, 32'h0000_0202, 32'h0,        32'h80FF_FF7F, 1, 0, 32'h0000_0200, 4'b1100, 32'h0,        32'h0000_80FF, 2,  0);
    vecs[4]  = mk("sh",    0, 1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 32'h0,        2, 0, 32'h0000_0010, 4'b1100, 32'hABCD_ABCD, 32'h0000_80FF, 3,  0);
    vecs[5]  = mk("sb",    0, 1, 3'b000, 32'h0000_0021, 32'h0000_00A5, 32'h0,        1, 0, 32'h0000_0020, 4'b0010, 32'hA5A5_A5A5, 32'h0000_80FF, 2,  0);
    vecs[6]  = mk("lh",    1, 0, 3'b001, 32'h0000_0300, 32'h0,        32'h1234_F00D, 1, 0, 32'h0000_0300, 4'b0011, 32'h0,        32'hFFFF_F00D, 2,  0);
    vecs[7]  = mk("sw",    0, 1, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 32'h0,        1, 0, 32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_F00D, 2,  0);
    vecs[8]  = mk("lw_mis",1, 0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_F00D, 0,  0);
    vecs[9]  = mk("sh_mis",0, 1, 3'b001, 32'h0000_0013, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_F00D, 0,  0);
    vecs[10] = mk("re_we", 1, 1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_F00D, 0,  0);
    vecs[11] = mk("sbu",   0, 1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_F00D, 0,  0);
    vecs[12] = mk("tmo",   1, 0, 3'b010, 32'h0000_0400, 32'h0,        32'h0,        0, 0, 32'h0000_0400, 4'b1111, 32'h0,        32'h0,        17, 1);

    #12;
    checkOutput("rst.bus_req",  {31'h0, bus_req}, 32'h0);
    checkOutput("rst.bus_addr", bus_addr, 32'h0);
    checkOutput("rst.dm_rd",    M_dm_rd, 32'h0);
    checkOutput("rst.stall",    {31'h0, M_stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle.fault", {31'h0, M_fault}, 32'h0);
    checkOutput("idle.err",   {31'h0, M_bus_err}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
    end

    // After the timeout, a stray ack with no request must change nothing.
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1111_2222;
    @(negedge clk);
    @(negedge clk);
    checkOutput("late_ack.req",   {31'h0, bus_req}, 32'h0);
    checkOutput("late_ack.dm_rd", M_dm_rd, 32'h0);
    checkOutput("late_ack.stall", {31'h0, M_stall}, 32'h0);
    bus_ack = 1'b0;

    // Reset in the middle of a BUSY phase.
    @(negedge clk);
    M_mem_re = 1'b1;
    M_funct3 = 3'b010;
    M_alu_o  = 32'h0000_0500;
    repeat (3) @(negedge clk);
    checkOutput("mid_rst.req_before", {31'h0, bus_req}, 32'h1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checkOutput("mid_rst.req",   {31'h0, bus_req}, 32'h0);
    checkOutput("mid_rst.addr",  bus_addr, 32'h0);
    checkOutput("mid_rst.be",    {28'h0, bus_be}, 32'h0);
    checkOutput("mid_rst.stall", {31'h0, M_stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v = mk("post_rst_lbu", 1, 0, 3'b100, 32'h0000_0501, 32'h0, 32'h0000_AB00, 2, 0,
           32'h0000_0500, 4'b0010, 32'h0, 32'h0000_00AB, 3, 0);
    applyStimulus(v);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
